// File: rtl/aes_gcm_issue_scheduler.sv
// AES-GCM issue scheduler: takes one instance descriptor, then streams its AAD and PT
// blocks as registered beats (J0, counter block, length word, flags) into stage 1.
module aes_gcm_issue_scheduler #(
    parameter int unsigned LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_desc_valid,
    output logic             o_desc_ready,
    input  logic [95:0]      i_iv,
    input  logic [LEN_W-1:0] i_aad_bytes,
    input  logic [LEN_W-1:0] i_pt_bytes,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    input  logic [127:0]     i_data,
    output logic             o_valid,
    output logic [127:0]     o_aad,
    output logic [127:0]     o_plain_text,
    output logic [127:0]     o_j0,
    output logic [127:0]     o_cb,
    output logic [127:0]     o_instance_size,
    output logic             o_new_instance,
    output logic             o_pt_instance,
    output logic             o_last
);

    typedef enum logic [1:0] {IDLE, AAD, PT, EMPTY} state_t;

    state_t           state_q, state_d;
    logic [95:0]      iv_q, iv_d;
    logic [LEN_W-1:0] aad_len_q, aad_len_d, pt_len_q, pt_len_d;
    logic [LEN_W-1:0] left_q, left_d, pt_blk_q, pt_blk_d;
    logic [31:0]      ctr_q, ctr_d;
    logic             first_q, first_d;
    logic             desc_ready_d, data_ready_d;

    logic             valid_d, new_d, pti_d, last_d;
    logic [127:0]     aad_d, pt_d, j0_d, cb_d, size_d;

    logic [LEN_W-1:0] n_aad, n_pt;

    function automatic logic [LEN_W-1:0] blocks(input logic [LEN_W-1:0] bytes);
        logic [LEN_W:0] sum;
        sum = {1'b0, bytes} + (LEN_W+1)'(15);
        return LEN_W'(sum >> 4);
    endfunction

    // Byte 0 is the most significant byte; bytes at and beyond rem are cleared.
    function automatic logic [127:0] tail_mask(input logic [127:0] blk, input logic [3:0] rem);
        logic [127:0] r;
        r = blk;
        if (rem != 4'd0) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (i >= {28'd0, rem}) r[127 - 8*i -: 8] = '0;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] len_bits(input logic [LEN_W-1:0] b);
        return 64'(b) << 3;
    endfunction

    assign n_aad = blocks(i_aad_bytes);
    assign n_pt  = blocks(i_pt_bytes);

    always_comb begin
        state_d   = state_q;
        iv_d      = iv_q;
        aad_len_d = aad_len_q;
        pt_len_d  = pt_len_q;
        left_d    = left_q;
        pt_blk_d  = pt_blk_q;
        ctr_d     = ctr_q;
        first_d   = first_q;
        valid_d   = 1'b0;
        new_d     = 1'b0;
        pti_d     = 1'b0;
        last_d    = 1'b0;
        aad_d     = '0;
        pt_d      = '0;
        j0_d      = '0;
        cb_d      = '0;
        size_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (i_desc_valid && o_desc_ready) begin
                    iv_d      = i_iv;
                    aad_len_d = i_aad_bytes;
                    pt_len_d  = i_pt_bytes;
                    pt_blk_d  = n_pt;
                    ctr_d     = 32'd2;
                    first_d   = 1'b1;
                    if (n_aad != '0) begin
                        state_d = AAD;
                        left_d  = n_aad;
                    end else if (n_pt != '0) begin
                        state_d = PT;
                        left_d  = n_pt;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            AAD: begin
                if (i_data_valid && o_data_ready) begin
                    valid_d = 1'b1;
                    new_d   = first_q;
                    first_d = 1'b0;
                    j0_d    = {iv_q, 32'd1};
                    size_d  = {len_bits(aad_len_q), len_bits(pt_len_q)};
                    aad_d   = tail_mask(i_data, (left_q == LEN_W'(1)) ? aad_len_q[3:0] : 4'd0);
                    left_d  = left_q - LEN_W'(1);
                    if (left_q == LEN_W'(1)) begin
                        if (pt_blk_q != '0) begin
                            state_d = PT;
                            left_d  = pt_blk_q;
                        end else begin
                            state_d = IDLE;
                            last_d  = 1'b1;
                        end
                    end
                end
            end
            PT: begin
                if (i_data_valid && o_data_ready) begin
                    valid_d = 1'b1;
                    new_d   = first_q;
                    first_d = 1'b0;
                    pti_d   = 1'b1;
                    j0_d    = {iv_q, 32'd1};
                    size_d  = {len_bits(aad_len_q), len_bits(pt_len_q)};
                    cb_d    = {iv_q, ctr_q};
                    ctr_d   = ctr_q + 32'd1;
                    pt_d    = tail_mask(i_data, (left_q == LEN_W'(1)) ? pt_len_q[3:0] : 4'd0);
                    left_d  = left_q - LEN_W'(1);
                    if (left_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                    end
                end
            end
            EMPTY: begin
                valid_d = 1'b1;
                new_d   = 1'b1;
                last_d  = 1'b1;
                first_d = 1'b0;
                j0_d    = {iv_q, 32'd1};
                size_d  = {len_bits(aad_len_q), len_bits(pt_len_q)};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Readies are registered so they stay low while reset is asserted.
        desc_ready_d = (state_d == IDLE);
        data_ready_d = (state_d == AAD) || (state_d == PT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            iv_q            <= '0;
            aad_len_q       <= '0;
            pt_len_q        <= '0;
            left_q          <= '0;
            pt_blk_q        <= '0;
            ctr_q           <= '0;
            first_q         <= 1'b0;
            o_desc_ready    <= 1'b0;
            o_data_ready    <= 1'b0;
            o_valid         <= 1'b0;
            o_aad           <= '0;
            o_plain_text    <= '0;
            o_j0            <= '0;
            o_cb            <= '0;
            o_instance_size <= '0;
            o_new_instance  <= 1'b0;
            o_pt_instance   <= 1'b0;
            o_last          <= 1'b0;
        end else begin
            state_q         <= state_d;
            iv_q            <= iv_d;
            aad_len_q       <= aad_len_d;
            pt_len_q        <= pt_len_d;
            left_q          <= left_d;
            pt_blk_q        <= pt_blk_d;
            ctr_q           <= ctr_d;
            first_q         <= first_d;
            o_desc_ready    <= desc_ready_d;
            o_data_ready    <= data_ready_d;
            o_valid         <= valid_d;
            o_aad           <= aad_d;
            o_plain_text    <= pt_d;
            o_j0            <= j0_d;
            o_cb            <= cb_d;
            o_instance_size <= size_d;
            o_new_instance  <= new_d;
            o_pt_instance   <= pti_d;
            o_last          <= last_d;
        end
    end

endmodule
